serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract controller for the Mips32bit datapath.
- Sequences one internal singlebit_full_adder instance over WIDTH cycles, LSB first, with a registered carry.
- Offers a low-area alternative to a ripple-carry array for ALU add/sub.
- Start/done handshake toward the ALU control.

Parameters:
- WIDTH, 32, operand and result width in bits; legal range 2..64.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- sub  input  1  0 = A+B, 1 = A-B; captured with start.
- op_a  input  WIDTH  operand A; captured with start.
- op_b  input  WIDTH  operand B; captured with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  WIDTH  sum or difference; held until the next accepted start.
- carry_out  output  1  carry out of MSB; for sub, 1 = no borrow.
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (synchronous, active-high, dominates all inputs) clears:
  - state to IDLE
  - busy, done, result, carry_out, overflow to 0
  - bit counter and shift registers to 0
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1, capture op_a into shift register SA.
  - Capture op_b into SB; if sub=1, capture ~op_b instead.
  - Set the carry register to sub.
  - Clear the counter to 0 and go to RUN.
  - With start=0, stay in IDLE; all outputs hold.
- RUN (busy=1):
  - Each cycle, feed the full adder a=SA[0], b=SB[0], carry_in=carry register.
  - Shift the sum bit into the result shift register from the MSB end (right shift).
  - Right-shift SA and SB.
  - Load the carry register with the adder carry_out.
  - Increment the counter.
  - On the cycle the counter equals WIDTH-1:
    - latch the adder carry_in as cin_msb
    - on the next edge, go to DONE
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - carry_out = final carry register; overflow = cin_msb XOR final carry.
  - result is fully assembled.
  - Next state is unconditionally IDLE.
- Latency: start accepted at edge N; done is high in the cycle after edge N+WIDTH. Total is WIDTH+1 cycles from start to the done cycle.
- Back-to-back requests: the earliest next accepted start is the cycle after done. Start asserted during RUN or DONE is ignored, not queued.
- Input timing: op_a, op_b and sub matter only in the start cycle. Changes during RUN have no effect.
- Output stability:
  - result, carry_out and overflow update only when leaving RUN.
  - They are stable from the done cycle until the RUN that follows the next accepted start completes.
  - They stay stable while the block idles.
- Reset mid-RUN: the operation is aborted, no done pulse is produced, and outputs return to 0 on the same edge.
- Width rules:
  - The counter is $clog2(WIDTH) bits wide.
  - The counter is compared, never wrapped; WIDTH need not be a power of two.
- Arithmetic:
  - result = (op_a + op_b) mod 2^WIDTH.
  - For sub: result = (op_a + ~op_b + 1) mod 2^WIDTH.

Optional Feature:
- Macro: SERIAL_ADD_ZERO_FLAG_EN.
- When defined, the block adds output port zero (1 bit).
  - A sticky accumulator is cleared on start acceptance and ORed with each sum bit during RUN.
  - zero = ~accumulator, updated on the transition to DONE and held like result.
  - Reset value is 0.
- When undefined, there is no zero port and no accumulator logic.
- All other behaviour is identical in both builds.

Test Plan:
- Add, WIDTH=32: start with A=0x0000_0005, B=0x0000_0003, sub=0.
  - busy for 32 cycles, then done.
  - result=0x0000_0008, carry_out=0, overflow=0.
- Carry/overflow: A=0xFFFF_FFFF, B=0x0000_0001, sub=0 -> result=0, carry_out=1, overflow=0, zero=1 (if enabled).
- Signed overflow: A=0x7FFF_FFFF, B=0x0000_0001, sub=0 -> result=0x8000_0000, overflow=1, carry_out=0.
- Subtract: A=3, B=5, sub=1 -> result=0xFFFF_FFFE, carry_out=0 (borrow), overflow=0.
- Start ignored while busy:
  - Accept a start, then pulse start again in RUN cycle 10 with different operands.
  - Exactly one done appears, with the first result.
  - A new start in the cycle after done is accepted.
- Reset mid-operation:
  - Assert reset in RUN cycle 16 -> the next cycle shows busy=0, result=0, and no done.
  - A subsequent add with WIDTH=8, A=0x80, B=0x80 gives result=0x00, carry_out=1, overflow=1 after 9 cycles.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract controller for the Mips32bit ALU.
// One singlebit_full_adder is reused over WIDTH cycles, LSB first, and the
// carry is kept in a register between cycles. start/done handshake to the ALU
// control. Optional build macro SERIAL_ADD_ZERO_FLAG_EN adds a 'zero' output
// that flags an all-zero result.

// One-bit full adder that the serial controller steps across the operand bits
module singlebit_full_adder (
   input  logic a,
   input  logic b,
   input  logic carry_in,
   output logic sum,
   output logic carry_out
);

   // Plain combinational sum and carry
   always_comb begin
      sum       = a ^ b ^ carry_in;
      carry_out = (a & b) | (a & carry_in) | (b & carry_in);
   end

endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
`ifdef SERIAL_ADD_ZERO_FLAG_EN
   ,
   output logic             zero
`endif
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;

   logic [WIDTH-1:0]   shift_a;
   logic [WIDTH-1:0]   shift_b;
   logic [WIDTH-1:0]   shift_sum;
   logic [CNT_W-1:0]   bit_cnt;
   logic               carry_q;

   logic               fa_sum;
   logic               fa_cout;
   logic               last_bit;
   logic               cin_msb;

`ifdef SERIAL_ADD_ZERO_FLAG_EN
   logic               nonzero_acc;
`endif

   // The adder only ever sees the current LSBs and the registered carry
   singlebit_full_adder u_fa (
      .a         (shift_a[0]),
      .b         (shift_b[0]),
      .carry_in  (carry_q),
      .sum       (fa_sum),
      .carry_out (fa_cout)
   );

   // The counter is compared against WIDTH-1 rather than allowed to wrap, so
   // non-power-of-two widths work; the carry feeding the MSB is cin_msb
   always_comb begin
      last_bit = (bit_cnt == CNT_W'(WIDTH - 1));
      cin_msb  = carry_q;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic: start only matters in IDLE, DONE always lasts one cycle
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs decoded straight from the state
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Datapath: capture operands on start, shift one bit per RUN cycle, and
   // publish result/flags only on the last bit so they hold between operations
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_a     <= '0;
         shift_b     <= '0;
         shift_sum   <= '0;
         bit_cnt     <= '0;
         carry_q     <= 1'b0;
         result      <= '0;
         carry_out   <= 1'b0;
         overflow    <= 1'b0;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
         nonzero_acc <= 1'b0;
         zero        <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  shift_a     <= op_a;
                  shift_b     <= sub ? ~op_b : op_b;
                  carry_q     <= sub;
                  bit_cnt     <= '0;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
                  nonzero_acc <= 1'b0;
`endif
               end
            end
            RUN: begin
               shift_a   <= shift_a >> 1;
               shift_b   <= shift_b >> 1;
               shift_sum <= {fa_sum, shift_sum[WIDTH-1:1]};
               carry_q   <= fa_cout;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
               nonzero_acc <= nonzero_acc | fa_sum;
`endif
               if (last_bit) begin
                  result    <= {fa_sum, shift_sum[WIDTH-1:1]};
                  carry_out <= fa_cout;
                  overflow  <= cin_msb ^ fa_cout;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
                  zero      <= ~(nonzero_acc | fa_sum);
`endif
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: self-checking bench for serial_add_ctrl. A 32-bit
// instance carries most scenarios; an 8-bit instance covers the narrow add
// after a mid-run reset. Expected results come from a reference model and
// are queued when a start is driven, then popped when done is seen.
`timescale 1ns/1ps

module tb_serial_add_ctrl;

   typedef struct {
      logic [63:0] res;
      logic        cout;
      logic        ovf;
      logic        zero;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, sub;
   logic [31:0] op_a, op_b;
   logic        busy, done, carry_out, overflow;
   logic [31:0] result;
   logic        start8, sub8;
   logic [7:0]  op_a8, op_b8;
   logic        busy8, done8, carry_out8, overflow8;
   logic [7:0]  result8;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
   logic        zero, zero8;
`endif

   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[$];

   serial_add_ctrl #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .sub(sub),
      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
      .result(result), .carry_out(carry_out), .overflow(overflow)
`ifdef SERIAL_ADD_ZERO_FLAG_EN
      , .zero(zero)
`endif
   );

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .sub(sub8),
      .op_a(op_a8), .op_b(op_b8), .busy(busy8), .done(done8),
      .result(result8), .carry_out(carry_out8), .overflow(overflow8)
`ifdef SERIAL_ADD_ZERO_FLAG_EN
      , .zero(zero8)
`endif
   );

   always #5 clk = ~clk;

   // Reference arithmetic, independent of the serial structure
   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                  input logic s, input int w);
      exp_t        m;
      logic [63:0] mask, am, bb, r;
      logic [64:0] full;
      mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      am     = a & mask;
      bb     = (s ? ~b : b) & mask;
      full   = {1'b0, am} + {1'b0, bb} + {64'd0, s};
      r      = full[63:0] & mask;
      m.res  = r;
      m.cout = full[w];
      m.ovf  = (am[w-1] == bb[w-1]) && (r[w-1] != am[w-1]);
      m.zero = (r == 64'd0);
      return m;
   endfunction

   // Drives a start for one cycle on the 32-bit instance and queues its result
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic s);
      op_a  = a;
      op_b  = b;
      sub   = s;
      start = 1'b1;
      exp_q.push_back(model({32'd0, a}, {32'd0, b}, s, 32));
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Waits on negedges for done, counting busy cycles; bounded
   task automatic wait_done(output int busy_cycles, output bit seen);
      busy_cycles = 0;
      seen        = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) busy_cycles++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
      start8 = 1'b0; sub8 = 1'b0; op_a8 = '0; op_b8 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, carry_out, overflow} !== 4'b0000 || result !== 32'd0) begin
         failures++;
         $display("[TB] FAIL reset_state: busy=%b done=%b result=%h cout=%b ovf=%b, required all 0",
                  busy, done, result, carry_out, overflow);
      end
`ifdef SERIAL_ADD_ZERO_FLAG_EN
      checks++;
      if (zero !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_zero: got %b, required 0", zero);
      end
`endif
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_add();
      logic [31:0] va[6];
      logic [31:0] vb[6];
      logic        vs[6];
      int          bc;
      bit          seen;
      exp_t        e;
      va = '{32'h5, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h3, $urandom, $urandom};
      vb = '{32'h3, 32'h1,         32'h1,         32'h5, $urandom, $urandom};
      vs = '{1'b0,  1'b0,          1'b0,          1'b1,  1'b0,     1'b1};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(va[i], vb[i], vs[i]);
         wait_done(bc, seen);
         checks++;
         if (!seen || bc != 32) begin
            failures++;
            $display("[TB] FAIL add%0d_latency: done_seen=%b busy_cycles=%0d, required done after 32",
                     i, seen, bc);
         end
         e = exp_q.pop_front();
         checks++;
         if (result !== e.res[31:0] || carry_out !== e.cout || overflow !== e.ovf) begin
            failures++;
            $display("[TB] FAIL add%0d_result: got %h c=%b v=%b, required %h c=%b v=%b",
                     i, result, carry_out, overflow, e.res[31:0], e.cout, e.ovf);
         end
`ifdef SERIAL_ADD_ZERO_FLAG_EN
         checks++;
         if (zero !== e.zero) begin
            failures++;
            $display("[TB] FAIL add%0d_zero: got %b, required %b", i, zero, e.zero);
         end
`endif
         // done is a single pulse and the outputs keep holding while idle
         repeat (3) @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || result !== e.res[31:0] || carry_out !== e.cout) begin
            failures++;
            $display("[TB] FAIL add%0d_hold: done=%b busy=%b result=%h c=%b, required 0 0 %h %b",
                     i, done, busy, result, carry_out, e.res[31:0], e.cout);
         end
      end
   endtask

   task automatic test_back_to_back();
      int   bc;
      int   done_cnt;
      bit   seen;
      exp_t e;
      applyStimulus(32'h1234_0000, 32'h0000_5678, 1'b0);
      // Reach RUN cycle 10 and fire a competing start with new operands
      repeat (9) @(negedge clk);
      op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; sub = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(bc, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || result !== e.res[31:0] || carry_out !== e.cout) begin
         failures++;
         $display("[TB] FAIL ignore_start_result: seen=%b got %h c=%b, required %h c=%b",
                  seen, result, carry_out, e.res[31:0], e.cout);
      end
      // Start in the cycle right after done must be accepted
      @(posedge clk);
      #1;
      applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      done_cnt = 0;
      for (int i = 0; i < 34; i++) begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            e = exp_q.pop_front();
            checks++;
            if (i != 32 || result !== e.res[31:0] || carry_out !== e.cout || overflow !== e.ovf) begin
               failures++;
               $display("[TB] FAIL b2b_result: cycle=%0d got %h c=%b v=%b, required cycle 32 %h c=%b v=%b",
                        i, result, carry_out, overflow, e.res[31:0], e.cout, e.ovf);
            end
         end
      end
      checks++;
      if (done_cnt != 1 || exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL b2b_done_count: dones=%0d pending=%0d, required 1 and 0",
                  done_cnt, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_run();
      int   bc;
      bit   seen;
      int   dones;
      exp_t e;
      applyStimulus(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
      void'(exp_q.pop_front());
      repeat (15) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
         failures++;
         $display("[TB] FAIL mid_reset_clear: busy=%b done=%b result=%h c=%b v=%b, required all 0",
                  busy, done, result, carry_out, overflow);
      end
      reset = 1'b0;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      checks++;
      if (dones != 0) begin
         failures++;
         $display("[TB] FAIL mid_reset_no_done: activity cycles=%0d, required 0", dones);
      end
      // 8-bit instance: 0x80 + 0x80
      e = model(64'h80, 64'h80, 1'b0, 8);
      op_a8 = 8'h80; op_b8 = 8'h80; sub8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      bc = 0; seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (done8) begin
            seen = 1'b1;
            break;
         end
         if (busy8) bc++;
      end
      checks++;
      if (!seen || bc != 8) begin
         failures++;
         $display("[TB] FAIL w8_latency: seen=%b busy_cycles=%0d, required done after 8", seen, bc);
      end
      checks++;
      if (result8 !== e.res[7:0] || carry_out8 !== e.cout || overflow8 !== e.ovf) begin
         failures++;
         $display("[TB] FAIL w8_result: got %h c=%b v=%b, required %h c=%b v=%b",
                  result8, carry_out8, overflow8, e.res[7:0], e.cout, e.ovf);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
